// File: rtl/layer_sequencer_if.sv
// Bus bundle between a layer sequencer, its upstream/downstream
// neighbours and the neuron array it drives.
interface layer_sequencer_if #(
    parameter int NUM_NEURON = 10,
    parameter int dataWidth  = 16
);
    logic [dataWidth-1:0]            s_data;
    logic                            s_valid;
    logic                            s_ready;
    logic [dataWidth-1:0]            neuron_in;
    logic                            neuron_in_valid;
    logic [NUM_NEURON*dataWidth-1:0] neuron_out;
    logic [NUM_NEURON-1:0]           neuron_outvalid;
    logic [dataWidth-1:0]            m_data;
    logic                            m_valid;
    logic                            m_ready;
    logic                            busy;
    logic                            timeout_err;

    modport master (
        input  s_data, s_valid, neuron_out, neuron_outvalid, m_ready,
        output s_ready, neuron_in, neuron_in_valid, m_data, m_valid,
        output busy, timeout_err
    );

    modport slave (
        output s_data, s_valid, neuron_out, neuron_outvalid, m_ready,
        input  s_ready, neuron_in, neuron_in_valid, m_data, m_valid,
        input  busy, timeout_err
    );
endinterface

// File: rtl/layer_sequencer.sv
// Buffers one layer's inputs, broadcasts them to the neurons as one
// gap-free burst, gathers every neuron result and streams them out.
module layer_sequencer #(
    parameter int NUM_INPUT  = 10,
    parameter int NUM_NEURON = 10,
    parameter int dataWidth  = 16,
    parameter int TIMEOUT    = 64
) (
    input logic clk,
    input logic rst,
    layer_sequencer_if.master bus
);
    localparam int IC = $clog2(NUM_INPUT + 1);
    localparam int OC = $clog2(NUM_NEURON + 1);
    localparam int TC = $clog2(TIMEOUT + 1);
    localparam int IA = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam int OA = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

    localparam logic [IC-1:0] IN_LAST  = IC'(NUM_INPUT - 1);
    localparam logic [IC-1:0] IN_END   = IC'(NUM_INPUT);
    localparam logic [IC-1:0] IN_ONE   = IC'(1);
    localparam logic [OC-1:0] OUT_LAST = OC'(NUM_NEURON - 1);
    localparam logic [OC-1:0] OUT_END  = OC'(NUM_NEURON);
    localparam logic [OC-1:0] OUT_ONE  = OC'(1);
    localparam logic [TC-1:0] TO_LAST  = TC'(TIMEOUT - 1);
    localparam logic [TC-1:0] TO_ONE   = TC'(1);

    typedef enum logic [1:0] {S_LOAD, S_FEED, S_WAIT, S_DRAIN} state_t;

    state_t state, state_nx;

    logic [IC-1:0] wr_cnt, wr_nx, rd_cnt, rd_nx;
    logic [OC-1:0] out_cnt, out_nx, sel;
    logic [TC-1:0] wt_cnt, wt_nx;
    logic [NUM_NEURON-1:0] cap_mask, mask_nx, mask_all;

    logic                 s_ready_q, s_ready_nx;
    logic [dataWidth-1:0] nin_q, nin_nx;
    logic                 nin_v_q, nin_v_nx;
    logic [dataWidth-1:0] m_data_q, m_data_nx, word;
    logic                 m_valid_q, m_valid_nx;
    logic                 busy_q, busy_nx;
    logic                 err_q, err_nx;
    logic                 in_we;

    logic [dataWidth-1:0] in_buf  [NUM_INPUT];
    logic [dataWidth-1:0] res_buf [NUM_NEURON];

    always_comb begin
        state_nx   = state;
        wr_nx      = wr_cnt;
        rd_nx      = rd_cnt;
        out_nx     = out_cnt;
        wt_nx      = wt_cnt;
        mask_nx    = cap_mask;
        s_ready_nx = s_ready_q;
        nin_nx     = nin_q;
        nin_v_nx   = nin_v_q;
        m_data_nx  = m_data_q;
        m_valid_nx = m_valid_q;
        busy_nx    = busy_q;
        err_nx     = err_q;
        in_we      = 1'b0;
        mask_all   = cap_mask | bus.neuron_outvalid;

        // Word to present next: current index on entry, else the following one.
        sel  = m_valid_q ? out_cnt + OUT_ONE : out_cnt;
        word = '0;
        if (sel != OUT_END && cap_mask[sel[OA-1:0]])
            word = res_buf[sel[OA-1:0]];

        unique case (state)
            S_LOAD: begin
                if (bus.s_valid && s_ready_q) begin
                    in_we = 1'b1;
                    wr_nx = wr_cnt + IN_ONE;
                    if (wr_cnt == IN_LAST) begin
                        wr_nx      = '0;
                        state_nx   = S_FEED;
                        s_ready_nx = 1'b0;
                        busy_nx    = 1'b1;
                    end
                end
            end
            S_FEED: begin
                if (rd_cnt != IN_END) begin
                    nin_nx   = in_buf[rd_cnt[IA-1:0]];
                    nin_v_nx = 1'b1;
                    rd_nx    = rd_cnt + IN_ONE;
                end else begin
                    nin_v_nx = 1'b0;
                    rd_nx    = '0;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                mask_nx = mask_all;
                if (&mask_all) begin
                    state_nx = S_DRAIN;
                    wt_nx    = '0;
                end else if (wt_cnt == TO_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = S_DRAIN;
                    wt_nx    = '0;
                end else begin
                    wt_nx = wt_cnt + TO_ONE;
                end
            end
            S_DRAIN: begin
                if (!m_valid_q) begin
                    m_valid_nx = 1'b1;
                    m_data_nx  = word;
                end else if (bus.m_ready) begin
                    if (out_cnt == OUT_LAST) begin
                        m_valid_nx = 1'b0;
                        mask_nx    = '0;
                        out_nx     = '0;
                        state_nx   = S_LOAD;
                        s_ready_nx = 1'b1;
                        busy_nx    = 1'b0;
                    end else begin
                        out_nx    = out_cnt + OUT_ONE;
                        m_data_nx = word;
                    end
                end
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            wt_cnt    <= '0;
            cap_mask  <= '0;
            s_ready_q <= 1'b1;
            nin_q     <= '0;
            nin_v_q   <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_cnt    <= wr_nx;
            rd_cnt    <= rd_nx;
            out_cnt   <= out_nx;
            wt_cnt    <= wt_nx;
            cap_mask  <= mask_nx;
            s_ready_q <= s_ready_nx;
            nin_q     <= nin_nx;
            nin_v_q   <= nin_v_nx;
            m_data_q  <= m_data_nx;
            m_valid_q <= m_valid_nx;
            busy_q    <= busy_nx;
            err_q     <= err_nx;
        end
    end

    // Data buffers carry no reset; validity is tracked by counters and cap_mask.
    always_ff @(posedge clk) begin
        if (in_we)
            in_buf[wr_cnt[IA-1:0]] <= bus.s_data;
        for (int k = 0; k < NUM_NEURON; k++)
            if (state == S_WAIT && bus.neuron_outvalid[k])
                res_buf[k] <= bus.neuron_out[k*dataWidth +: dataWidth];
    end

    assign bus.s_ready         = s_ready_q;
    assign bus.neuron_in       = nin_q;
    assign bus.neuron_in_valid = nin_v_q;
    assign bus.m_data          = m_data_q;
    assign bus.m_valid         = m_valid_q;
    assign bus.busy            = busy_q;
    assign bus.timeout_err     = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: load/feed, capture, drain
// stalls, timeout and mid-run reset.
module tb_layer_sequencer;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int TO = 20;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    layer_sequencer_if #(.NUM_NEURON(NN), .dataWidth(DW)) bus ();

    layer_sequencer #(
        .NUM_INPUT(NI), .NUM_NEURON(NN), .dataWidth(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_outs(input logic [2:0] v, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] c);
        bus.neuron_outvalid = v;
        bus.neuron_out      = {c, b, a};
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        logic [15:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = w[i];
            tick();
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic skip_feed();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        set_outs(3'b000, 16'h0, 16'h0, 16'h0);
        #12;
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_s_ready got %b exp 1", bus.s_ready);
        end
        checks++;
        if (bus.neuron_in_valid !== 1'b0 || bus.neuron_in !== 16'h0) begin
            errors++;
            $display("FAIL rst_nin got %b/%h exp 0/0000",
                     bus.neuron_in_valid, bus.neuron_in);
        end
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_m got %b/%h exp 0/0000", bus.m_valid, bus.m_data);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got %b/%b exp 0/0", bus.busy, bus.timeout_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_feed();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h0100; exp_w[1] = 16'h0200;
        exp_w[2] = 16'h0300; exp_w[3] = 16'h0400;
        do_load(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        // Offered beats while not ready must be dropped.
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hBEEF;
        checks++;
        if (bus.s_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL feed_ready got %b/%b exp 0/1", bus.s_ready, bus.busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.neuron_in_valid !== 1'b1 || bus.neuron_in !== exp_w[i]) begin
                errors++;
                $display("FAIL feed_word%0d got %b/%h exp 1/%h", i,
                         bus.neuron_in_valid, bus.neuron_in, exp_w[i]);
            end
        end
        tick();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        checks++;
        if (bus.neuron_in_valid !== 1'b0) begin
            errors++; $display("FAIL feed_end got %b exp 0", bus.neuron_in_valid);
        end
    endtask

    task automatic test_all_at_once();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0011; exp_d[1] = 16'h0022; exp_d[2] = 16'h0033;
        set_outs(3'b111, 16'h0011, 16'h0022, 16'h0033);
        tick();
        set_outs(3'b000, 16'h0, 16'h0, 16'h0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i]) begin
                errors++;
                $display("FAIL once_word%0d got %b/%h exp 1/%h", i,
                         bus.m_valid, bus.m_data, exp_d[i]);
            end
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL once_done got v%b r%b b%b exp v0 r1 b0",
                     bus.m_valid, bus.s_ready, bus.busy);
        end
        bus.m_ready = 1'b0;
    endtask

    task automatic test_staggered();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0A0A; exp_d[1] = 16'h0B0B; exp_d[2] = 16'h0C0C;
        do_load(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        skip_feed();
        repeat (4) tick();
        set_outs(3'b001, 16'h0A0A, 16'h1111, 16'h2222);
        tick();
        set_outs(3'b000, 16'hDEAD, 16'h1111, 16'h2222);
        tick();
        set_outs(3'b010, 16'hDEAD, 16'h0B0B, 16'h2222);
        tick();
        set_outs(3'b000, 16'hDEAD, 16'hDEAD, 16'h2222);
        tick();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stag_early got v%b b%b exp v0 b1", bus.m_valid, bus.busy);
        end
        set_outs(3'b100, 16'hDEAD, 16'hDEAD, 16'h0C0C);
        tick();
        set_outs(3'b000, 16'hBAD0, 16'hBAD1, 16'hBAD2);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i]) begin
                errors++;
                $display("FAIL stag_word%0d got %b/%h exp 1/%h", i,
                         bus.m_valid, bus.m_data, exp_d[i]);
            end
        end
        tick();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL stag_done got %b exp 1", bus.s_ready);
        end
    endtask

    task automatic test_stall();
        logic       rdy [5];
        logic [15:0] exp_d [5];
        rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1; rdy[4] = 1;
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h2222;
        exp_d[3] = 16'h2222; exp_d[4] = 16'h3333;
        do_load(16'h0005, 16'h0006, 16'h0007, 16'h0008);
        skip_feed();
        set_outs(3'b111, 16'h1111, 16'h2222, 16'h3333);
        tick();
        set_outs(3'b000, 16'h0, 16'h0, 16'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i]) begin
                errors++;
                $display("FAIL stall_cyc%0d got %b/%h exp 1/%h", i,
                         bus.m_valid, bus.m_data, exp_d[i]);
            end
            bus.m_ready = rdy[i];
            // Late outvalid during DRAIN must not corrupt results.
            if (i == 1) set_outs(3'b111, 16'hEEEE, 16'hEEEE, 16'hEEEE);
            else        set_outs(3'b000, 16'h0, 16'h0, 16'h0);
            tick();
        end
        set_outs(3'b000, 16'h0, 16'h0, 16'h0);
        bus.m_ready = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_done got v%b r%b exp v0 r1", bus.m_valid, bus.s_ready);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0055; exp_d[1] = 16'h0000; exp_d[2] = 16'h0077;
        do_load(16'h0009, 16'h000A, 16'h000B, 16'h000C);
        skip_feed();
        set_outs(3'b101, 16'h0055, 16'h0099, 16'h0077);
        tick();
        set_outs(3'b000, 16'h0, 16'h0, 16'h0);
        repeat (18) tick();
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_early got e%b v%b exp e0 v0",
                     bus.timeout_err, bus.m_valid);
        end
        tick();
        checks++;
        if (bus.timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_err got %b exp 1", bus.timeout_err);
        end
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i]) begin
                errors++;
                $display("FAIL to_word%0d got %b/%h exp 1/%h", i,
                         bus.m_valid, bus.m_data, exp_d[i]);
            end
        end
        tick();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL to_sticky got e%b b%b exp e1 b0",
                     bus.timeout_err, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0C01; exp_d[1] = 16'h0C02; exp_d[2] = 16'h0C03;
        do_load(16'h00A0, 16'h00B0, 16'h00C0, 16'h00D0);
        repeat (3) tick();
        checks++;
        if (bus.neuron_in_valid !== 1'b1 || bus.neuron_in !== 16'h00C0) begin
            errors++;
            $display("FAIL mid_pre got %b/%h exp 1/00c0",
                     bus.neuron_in_valid, bus.neuron_in);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.neuron_in_valid !== 1'b0 || bus.neuron_in !== 16'h0 ||
            bus.s_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got v%b d%h r%b b%b e%b exp v0 d0000 r1 b0 e0",
                     bus.neuron_in_valid, bus.neuron_in, bus.s_ready,
                     bus.busy, bus.timeout_err);
        end
        #10 rst = 1'b0;
        tick();
        do_load(16'h0111, 16'h0222, 16'h0333, 16'h0444);
        tick();
        checks++;
        if (bus.neuron_in_valid !== 1'b1 || bus.neuron_in !== 16'h0111) begin
            errors++;
            $display("FAIL mid_refeed got %b/%h exp 1/0111",
                     bus.neuron_in_valid, bus.neuron_in);
        end
        repeat (4) tick();
        set_outs(3'b111, 16'h0C01, 16'h0C02, 16'h0C03);
        tick();
        set_outs(3'b000, 16'h0, 16'h0, 16'h0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i]) begin
                errors++;
                $display("FAIL mid_word%0d got %b/%h exp 1/%h", i,
                         bus.m_valid, bus.m_data, exp_d[i]);
            end
        end
        tick();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_done got v%b r%b exp v0 r1", bus.m_valid, bus.s_ready);
        end
    endtask

    initial begin
        test_reset();
        test_feed();
        test_all_at_once();
        test_staggered();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
